// File: rtl/cache_req_pkg.sv
// Shared types and cache-geometry constants for the cache request issuer.
//   cache_req_t : one padded luma + chroma reference-block request
//   req_state_e : active-descriptor state (EMPTY / OFFER / HOLD)
//   sat_delta / span_ovf : clamp a block span to the 2-bit delta range
package cache_req_pkg;

    localparam int unsigned X_ADDR_WDTH   = 12;
    localparam int unsigned Y_ADDR_WDTH   = 12;
    localparam int unsigned LUMA_DIM_WDTH = 7;
    localparam int unsigned CHMA_DIM_WDTH = 6;
    localparam int unsigned CHMA_DIM_HIGT = 6;
    localparam int unsigned C_L_H_SIZE    = 3;
    localparam int unsigned C_L_V_SIZE    = 3;
    localparam int unsigned C_L_H_SIZE_C  = 2;
    localparam int unsigned C_SUB_WIDTH   = 2;
    localparam int unsigned C_SUB_HEIGHT  = 2;

    localparam int unsigned X_CH_WDTH  = X_ADDR_WDTH - (C_SUB_WIDTH - 1);
    localparam int unsigned Y_CH_WDTH  = Y_ADDR_WDTH - (C_SUB_HEIGHT - 1);
    localparam int unsigned DELTA_WDTH = 2;
    localparam int unsigned DELTA_MAX  = 3;

    // Widest span intermediate: one bit above the widest address.
    localparam int unsigned SPAN_WDTH =
        ((X_ADDR_WDTH > Y_ADDR_WDTH) ? X_ADDR_WDTH : Y_ADDR_WDTH) + 1;

    typedef struct packed {
        logic [X_ADDR_WDTH-1:0]   x;
        logic [Y_ADDR_WDTH-1:0]   y;
        logic [LUMA_DIM_WDTH-1:0] w;
        logic [LUMA_DIM_WDTH-1:0] h;
        logic [X_CH_WDTH-1:0]     x_ch;
        logic [Y_CH_WDTH-1:0]     y_ch;
        logic [CHMA_DIM_WDTH-1:0] w_ch;
        logic [CHMA_DIM_HIGT-1:0] h_ch;
        logic                     is_read;
    } cache_req_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } req_state_e;

    function automatic logic span_ovf(input logic [SPAN_WDTH-1:0] d);
        return d > SPAN_WDTH'(DELTA_MAX);
    endfunction

    function automatic logic [DELTA_WDTH-1:0] sat_delta(input logic [SPAN_WDTH-1:0] d);
        return span_ovf(d) ? DELTA_WDTH'(DELTA_MAX) : d[DELTA_WDTH-1:0];
    endfunction

endpackage

// File: rtl/cache_span_calc.sv
// Combinational span calculator: from one request derive the union start of the
// luma and chroma rectangles (in luma units) and the cache-block spans (minus 1).
//   req              : request to evaluate
//   great_x_c/_y_c   : union start, luma units
//   delta_*_c        : saturated block spans minus 1
//   ovf_c            : at least one span exceeded the delta range
module cache_span_calc
    import cache_req_pkg::*;
(
    input  cache_req_t              req,
    output logic [X_ADDR_WDTH-1:0]  great_x_c,
    output logic [Y_ADDR_WDTH-1:0]  great_y_c,
    output logic [DELTA_WDTH-1:0]   delta_x_c,
    output logic [DELTA_WDTH-1:0]   delta_y_c,
    output logic [DELTA_WDTH-1:0]   delta_x_luma_c,
    output logic [DELTA_WDTH-1:0]   delta_x_chma_c,
    output logic                    ovf_c
);

    localparam int unsigned XW = X_ADDR_WDTH + 1;
    localparam int unsigned YW = Y_ADDR_WDTH + 1;
    localparam int unsigned CW = X_CH_WDTH + 1;

    logic [XW-1:0] x_e, le_x, cs_x, ce_x, gs_x, ge_x, span_x, span_xl;
    logic [YW-1:0] y_e, le_y, cs_y, ce_y, gs_y, ge_y, span_y;
    logic [CW-1:0] xc_e, ce_xc, span_xc;
    logic          unused_is_read;

    assign unused_is_read = req.is_read;

    // Horizontal: luma end, chroma rectangle scaled to luma units, union.
    always_comb begin
        x_e     = XW'(req.x);
        le_x    = x_e + XW'(req.w) - XW'(1);
        cs_x    = XW'(req.x_ch) << (C_SUB_WIDTH - 1);
        ce_x    = ((XW'(req.x_ch) + XW'(req.w_ch)) << (C_SUB_WIDTH - 1)) - XW'(1);
        gs_x    = (x_e < cs_x) ? x_e : cs_x;
        ge_x    = (le_x > ce_x) ? le_x : ce_x;
        span_x  = (ge_x >> C_L_H_SIZE) - (gs_x >> C_L_H_SIZE);
        span_xl = (le_x >> C_L_H_SIZE) - (x_e >> C_L_H_SIZE);
    end

    // Vertical union in luma units.
    always_comb begin
        y_e    = YW'(req.y);
        le_y   = y_e + YW'(req.h) - YW'(1);
        cs_y   = YW'(req.y_ch) << (C_SUB_HEIGHT - 1);
        ce_y   = ((YW'(req.y_ch) + YW'(req.h_ch)) << (C_SUB_HEIGHT - 1)) - YW'(1);
        gs_y   = (y_e < cs_y) ? y_e : cs_y;
        ge_y   = (le_y > ce_y) ? le_y : ce_y;
        span_y = (ge_y >> C_L_V_SIZE) - (gs_y >> C_L_V_SIZE);
    end

    // Chroma-only horizontal span in chroma cache blocks.
    always_comb begin
        xc_e    = CW'(req.x_ch);
        ce_xc   = xc_e + CW'(req.w_ch) - CW'(1);
        span_xc = (ce_xc >> C_L_H_SIZE_C) - (xc_e >> C_L_H_SIZE_C);
    end

    assign great_x_c      = gs_x[X_ADDR_WDTH-1:0];
    assign great_y_c      = gs_y[Y_ADDR_WDTH-1:0];
    assign delta_x_c      = sat_delta(SPAN_WDTH'(span_x));
    assign delta_y_c      = sat_delta(SPAN_WDTH'(span_y));
    assign delta_x_luma_c = sat_delta(SPAN_WDTH'(span_xl));
    assign delta_x_chma_c = sat_delta(SPAN_WDTH'(span_xc));
    assign ovf_c          = span_ovf(SPAN_WDTH'(span_x))  | span_ovf(SPAN_WDTH'(span_y)) |
                            span_ovf(SPAN_WDTH'(span_xl)) | span_ovf(SPAN_WDTH'(span_xc));

endmodule

// File: rtl/cache_req_issue.sv
// Cache request issuer: one-entry pending buffer feeding an active descriptor that
// is offered on valid_out/set_input_ready and held frozen for the whole burst.
//   req_*             : incoming padded reference-block request, req_ready = buffer empty
//   valid_out         : descriptor offered to the set-input stage
//   set_input_ready   : set-input stage ready (low while its burst runs)
//   descriptor outs   : registered copy of the active request plus union start and spans
//   err_span          : sticky, some loaded request had a span beyond the delta range
module cache_req_issue
    import cache_req_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_read,
    input  logic [X_ADDR_WDTH-1:0]   req_x,
    input  logic [Y_ADDR_WDTH-1:0]   req_y,
    input  logic [LUMA_DIM_WDTH-1:0] req_w,
    input  logic [LUMA_DIM_WDTH-1:0] req_h,
    input  logic [X_CH_WDTH-1:0]     req_x_ch,
    input  logic [Y_CH_WDTH-1:0]     req_y_ch,
    input  logic [CHMA_DIM_WDTH-1:0] req_w_ch,
    input  logic [CHMA_DIM_HIGT-1:0] req_h_ch,
    output logic                     valid_out,
    input  logic                     set_input_ready,
    output logic                     is_req_read_out,
    output logic [X_ADDR_WDTH-1:0]   start_x_in,
    output logic [Y_ADDR_WDTH-1:0]   start_y_in,
    output logic [X_CH_WDTH-1:0]     start_x_ch,
    output logic [Y_CH_WDTH-1:0]     start_y_ch,
    output logic [LUMA_DIM_WDTH-1:0] rf_blk_wdth_in,
    output logic [LUMA_DIM_WDTH-1:0] rf_blk_hght_in,
    output logic [CHMA_DIM_WDTH-1:0] rf_blk_wdth_ch,
    output logic [CHMA_DIM_HIGT-1:0] rf_blk_hght_ch,
    output logic [X_ADDR_WDTH-1:0]   start_great_x_in,
    output logic [Y_ADDR_WDTH-1:0]   start_great_y_in,
    output logic [DELTA_WDTH-1:0]    delta_x,
    output logic [DELTA_WDTH-1:0]    delta_y,
    output logic [DELTA_WDTH-1:0]    delta_x_luma,
    output logic [DELTA_WDTH-1:0]    delta_x_chma,
    output logic                     err_span
);

    cache_req_t  req_in, pend_q;
    logic        pend_full_q, pend_full_nxt, capture, load;
    req_state_e  state_q, state_nxt;

    logic [X_ADDR_WDTH-1:0] great_x_c;
    logic [Y_ADDR_WDTH-1:0] great_y_c;
    logic [DELTA_WDTH-1:0]  delta_x_c, delta_y_c, delta_x_luma_c, delta_x_chma_c;
    logic                   ovf_c;

    assign req_in = '{x: req_x, y: req_y, w: req_w, h: req_h,
                      x_ch: req_x_ch, y_ch: req_y_ch, w_ch: req_w_ch, h_ch: req_h_ch,
                      is_read: req_is_read};

    assign capture = req_valid & req_ready;
    // A load and a capture in the same cycle leave the buffer full with the new entry.
    assign pend_full_nxt = capture | (pend_full_q & ~load);

    // Spans are evaluated on the pending entry so they are ready at load time.
    cache_span_calc u_span (
        .req            (pend_q),
        .great_x_c      (great_x_c),
        .great_y_c      (great_y_c),
        .delta_x_c      (delta_x_c),
        .delta_y_c      (delta_y_c),
        .delta_x_luma_c (delta_x_luma_c),
        .delta_x_chma_c (delta_x_chma_c),
        .ovf_c          (ovf_c)
    );

    // Pending buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            if (capture) pend_q <= req_in;
            pend_full_q <= pend_full_nxt;
            req_ready   <= ~pend_full_nxt;
        end
    end

    // Active-descriptor state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_nxt;
    end

    // Next state and load strobe; a burst ends on the first HOLD cycle with ready high.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (pend_full_q) begin
                    load      = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (set_input_ready) state_nxt = HOLD;
            end
            HOLD: begin
                if (set_input_ready) begin
                    if (pend_full_q) begin
                        load      = 1'b1;
                        state_nxt = OFFER;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Registered descriptor; only changes on load so it stays frozen through HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out        <= 1'b0;
            is_req_read_out  <= 1'b0;
            start_x_in       <= '0;
            start_y_in       <= '0;
            start_x_ch       <= '0;
            start_y_ch       <= '0;
            rf_blk_wdth_in   <= '0;
            rf_blk_hght_in   <= '0;
            rf_blk_wdth_ch   <= '0;
            rf_blk_hght_ch   <= '0;
            start_great_x_in <= '0;
            start_great_y_in <= '0;
            delta_x          <= '0;
            delta_y          <= '0;
            delta_x_luma     <= '0;
            delta_x_chma     <= '0;
            err_span         <= 1'b0;
        end else begin
            valid_out <= (state_nxt == OFFER);
            if (load) begin
                is_req_read_out  <= pend_q.is_read;
                start_x_in       <= pend_q.x;
                start_y_in       <= pend_q.y;
                start_x_ch       <= pend_q.x_ch;
                start_y_ch       <= pend_q.y_ch;
                rf_blk_wdth_in   <= pend_q.w;
                rf_blk_hght_in   <= pend_q.h;
                rf_blk_wdth_ch   <= pend_q.w_ch;
                rf_blk_hght_ch   <= pend_q.h_ch;
                start_great_x_in <= great_x_c;
                start_great_y_in <= great_y_c;
                delta_x          <= delta_x_c;
                delta_y          <= delta_y_c;
                delta_x_luma     <= delta_x_luma_c;
                delta_x_chma     <= delta_x_chma_c;
                err_span         <= err_span | ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_cache_req_issue.sv
// Self-checking bench for cache_req_issue: directed scenarios plus randomized
// traffic, scored against a request-level model of spans and handshake order.
module tb_cache_req_issue;

    localparam int LBW = 8;   // luma cache block width  (pixels)
    localparam int LBH = 8;   // luma cache block height (pixels)
    localparam int CBW = 4;   // chroma cache block width
    localparam int SUBX = 2;
    localparam int SUBY = 2;

    typedef struct {
        int x, y, w, h, xc, yc, wc, hc;
        bit rd;
    } rq_t;

    logic        clk, reset_n;
    logic        req_valid, req_ready, req_is_read;
    logic [11:0] req_x, req_y;
    logic [6:0]  req_w, req_h;
    logic [10:0] req_x_ch, req_y_ch;
    logic [5:0]  req_w_ch, req_h_ch;
    logic        valid_out, set_input_ready, is_req_read_out;
    logic [11:0] start_x_in, start_y_in, start_great_x_in, start_great_y_in;
    logic [10:0] start_x_ch, start_y_ch;
    logic [6:0]  rf_blk_wdth_in, rf_blk_hght_in;
    logic [5:0]  rf_blk_wdth_ch, rf_blk_hght_ch;
    logic [1:0]  delta_x, delta_y, delta_x_luma, delta_x_chma;
    logic        err_span;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] cur_desc;
    bit           in_burst, hold, err_exp;

    cache_req_issue dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_read(req_is_read),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_x_ch(req_x_ch), .req_y_ch(req_y_ch), .req_w_ch(req_w_ch), .req_h_ch(req_h_ch),
        .valid_out(valid_out), .set_input_ready(set_input_ready),
        .is_req_read_out(is_req_read_out),
        .start_x_in(start_x_in), .start_y_in(start_y_in),
        .start_x_ch(start_x_ch), .start_y_ch(start_y_ch),
        .rf_blk_wdth_in(rf_blk_wdth_in), .rf_blk_hght_in(rf_blk_hght_in),
        .rf_blk_wdth_ch(rf_blk_wdth_ch), .rf_blk_hght_ch(rf_blk_hght_ch),
        .start_great_x_in(start_great_x_in), .start_great_y_in(start_great_y_in),
        .delta_x(delta_x), .delta_y(delta_y),
        .delta_x_luma(delta_x_luma), .delta_x_chma(delta_x_chma),
        .err_span(err_span)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic rq_t mk(input int x, y, w, h, xc, yc, wc, hc, input bit rd);
        rq_t r;
        r.x = x; r.y = y; r.w = w; r.h = h;
        r.xc = xc; r.yc = yc; r.wc = wc; r.hc = hc; r.rd = rd;
        return r;
    endfunction

    function automatic int sat3(input int d, inout bit ovf);
        if (d > 3) begin
            ovf = 1'b1;
            return 3;
        end
        return d;
    endfunction

    // Expected descriptor: bit 127 = overflow flag, bits 104:0 = output fields.
    function automatic logic [127:0] model(input rq_t r);
        int le_x, cs_x, ce_x, gsx, gex, le_y, cs_y, ce_y, gsy, gey;
        int dx, dy, dl, dc;
        bit ovf;
        ovf  = 1'b0;
        le_x = r.x + r.w - 1;
        cs_x = r.xc * SUBX;
        ce_x = (r.xc + r.wc) * SUBX - 1;
        gsx  = (r.x < cs_x) ? r.x : cs_x;
        gex  = (le_x > ce_x) ? le_x : ce_x;
        le_y = r.y + r.h - 1;
        cs_y = r.yc * SUBY;
        ce_y = (r.yc + r.hc) * SUBY - 1;
        gsy  = (r.y < cs_y) ? r.y : cs_y;
        gey  = (le_y > ce_y) ? le_y : ce_y;
        dx = sat3(gex / LBW - gsx / LBW, ovf);
        dy = sat3(gey / LBH - gsy / LBH, ovf);
        dl = sat3(le_x / LBW - r.x / LBW, ovf);
        dc = sat3((r.xc + r.wc - 1) / CBW - r.xc / CBW, ovf);
        return {ovf, 22'd0, r.rd, 12'(r.x), 12'(r.y), 7'(r.w), 7'(r.h),
                11'(r.xc), 11'(r.yc), 6'(r.wc), 6'(r.hc), 12'(gsx), 12'(gsy),
                2'(dx), 2'(dy), 2'(dl), 2'(dc)};
    endfunction

    function automatic logic [127:0] obs();
        return {23'd0, is_req_read_out, start_x_in, start_y_in, rf_blk_wdth_in, rf_blk_hght_in,
                start_x_ch, start_y_ch, rf_blk_wdth_ch, rf_blk_hght_ch,
                start_great_x_in, start_great_y_in, delta_x, delta_y, delta_x_luma, delta_x_chma};
    endfunction

    function automatic rq_t rand_req();
        rq_t r;
        r.x  = $urandom_range(0, 4000);
        r.y  = $urandom_range(0, 4000);
        r.w  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 127) : $urandom_range(1, 16);
        r.h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 127) : $urandom_range(1, 16);
        r.xc = r.x / 2;
        r.yc = r.y / 2;
        r.wc = (r.w + 1) / 2 + $urandom_range(0, 1);
        r.hc = (r.h + 1) / 2 + $urandom_range(0, 1);
        if (r.wc > 63) r.wc = 63;
        if (r.hc > 63) r.hc = 63;
        r.rd = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // One clock: drive inputs, advance, then score outputs against the model.
    task automatic step(input bit rv, input rq_t r, input bit sir);
        bit acc, exp_offer;
        logic [127:0] e;
        req_valid = rv;   req_is_read = r.rd;
        req_x = 12'(r.x); req_y = 12'(r.y); req_w = 7'(r.w); req_h = 7'(r.h);
        req_x_ch = 11'(r.xc); req_y_ch = 11'(r.yc); req_w_ch = 6'(r.wc); req_h_ch = 6'(r.hc);
        set_input_ready = sir;
        acc = rv && req_ready;
        if (in_burst && hold && sir)  in_burst = 1'b0;
        else if (in_burst && sir)     hold = 1'b1;
        exp_offer = !in_burst && (exp_q.size() > 0);
        if (acc) exp_q.push_back(model(r));
        @(posedge clk);
        @(negedge clk);
        if (exp_offer) begin
            check("offer_start", 128'(valid_out), 128'(1));
            e = exp_q.pop_front();
            cur_desc = {23'd0, e[104:0]};
            check("desc_load", obs(), cur_desc);
            err_exp  = err_exp | e[127];
            in_burst = 1'b1;
            hold     = 1'b0;
        end else if (in_burst) begin
            check("valid_burst", 128'(valid_out), 128'(!hold));
            check("desc_frozen", obs(), cur_desc);
        end else begin
            check("valid_idle", 128'(valid_out), 128'(0));
        end
        check("req_ready", 128'(req_ready), 128'(exp_q.size() == 0));
        check("err_span", 128'(err_span), 128'(err_exp));
    endtask

    rq_t ra, rb, rc, rd_, re, rz;

    initial begin
        rz  = mk(0, 0, 1, 1, 0, 0, 1, 1, 1'b0);
        ra  = mk(13, 0, 16, 8, 6, 0, 8, 4, 1'b1);
        rb  = mk(0, 0, 8, 8, 0, 0, 4, 4, 1'b0);
        rc  = mk(100, 40, 20, 12, 50, 20, 10, 6, 1'b1);
        rd_ = mk(300, 200, 9, 9, 150, 100, 5, 5, 1'b0);
        re  = mk(1, 0, 40, 8, 0, 0, 20, 4, 1'b0);
        in_burst = 1'b0; hold = 1'b0; err_exp = 1'b0; cur_desc = '0;
        req_valid = 1'b0; req_is_read = 1'b0; set_input_ready = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        req_x_ch = '0; req_y_ch = '0; req_w_ch = '0; req_h_ch = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'(1));
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_err", 128'(err_span), 128'(0));
        check("rst_desc", obs(), 128'(0));
        reset_n = 1'b1;

        // Luma-only span, 1-cycle latency, 10 cycles of backpressure, frozen HOLD.
        step(1'b1, ra, 1'b0);
        check("lat_not_yet", 128'(valid_out), 128'(0));
        step(1'b0, rz, 1'b0);
        check("lat_valid", 128'(valid_out), 128'(1));
        check("luma_gx", 128'(start_great_x_in), 128'(12));
        check("luma_dx", 128'(delta_x), 128'(2));
        check("luma_dxl", 128'(delta_x_luma), 128'(2));
        check("luma_dxc", 128'(delta_x_chma), 128'(2));
        check("luma_dy", 128'(delta_y), 128'(0));
        repeat (10) step(1'b0, rz, 1'b0);
        check("bp_valid", 128'(valid_out), 128'(1));
        step(1'b0, rz, 1'b1);
        repeat (3) step(1'b0, rz, 1'b0);
        check("hold_gx", 128'(start_great_x_in), 128'(12));
        step(1'b0, rz, 1'b1);
        step(1'b0, rz, 1'b0);
        check("luma_done", 128'(valid_out), 128'(0));

        // 1x1 burst with set_input_ready held high.
        step(1'b1, rb, 1'b1);
        step(1'b0, rz, 1'b1);
        check("one_deltas", 128'({delta_x, delta_y, delta_x_luma, delta_x_chma}), 128'(0));
        step(1'b0, rz, 1'b1);
        check("one_hold", 128'(valid_out), 128'(0));
        step(1'b0, rz, 1'b1);
        check("one_empty", 128'(valid_out), 128'(0));

        // Back-to-back: second request captured during HOLD.
        step(1'b1, rc, 1'b0);
        step(1'b0, rz, 1'b0);
        step(1'b0, rz, 1'b1);
        step(1'b1, rd_, 1'b0);
        check("b2b_ready", 128'(req_ready), 128'(0));
        step(1'b0, rz, 1'b0);
        step(1'b0, rz, 1'b1);
        check("b2b_second", 128'(valid_out), 128'(1));
        check("b2b_sx", 128'(start_x_in), 128'(300));
        step(1'b0, rz, 1'b1);
        step(1'b0, rz, 1'b1);

        // Overflow saturates and err_span stays set across later requests.
        step(1'b1, re, 1'b0);
        step(1'b0, rz, 1'b0);
        check("ovf_dxl", 128'(delta_x_luma), 128'(3));
        check("ovf_err", 128'(err_span), 128'(1));
        step(1'b0, rz, 1'b1);
        step(1'b0, rz, 1'b1);
        step(1'b1, rb, 1'b0);
        step(1'b0, rz, 1'b0);
        step(1'b0, rz, 1'b1);
        step(1'b0, rz, 1'b0);
        check("sticky_err", 128'(err_span), 128'(1));

        // Async reset in the middle of HOLD.
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 128'(valid_out), 128'(0));
        check("arst_ready", 128'(req_ready), 128'(1));
        check("arst_err", 128'(err_span), 128'(0));
        check("arst_desc", obs(), 128'(0));
        @(negedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete();
        in_burst = 1'b0; hold = 1'b0; err_exp = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), rand_req(), ($urandom_range(0, 3) != 0));
        end
        repeat (20) step(1'b0, rz, 1'b1);
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        check("drain_idle", 128'(valid_out), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
